// File: rtl/ram_bus_master.sv
// Sequential bus master between the CPU load/store stage and a combinational word RAM.
// Range-checks one request at a time and steps the RAM through SETUP/ACCESS phases.
module ram_bus_master #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       RAM_LAST  = 99,
    parameter int unsigned       WAIT_CYC  = 1,
    parameter logic [ADDR_W-1:0] PARK_ADDR = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_w_r,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam int unsigned       CNT_W     = 4;
    // A zero wait count would never leave ACCESS correctly; clamp it to one cycle.
    localparam int unsigned       WAIT_EFF  = (WAIT_CYC == 0) ? 1 : WAIT_CYC;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_EFF - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_LAST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_w_r_q, ram_w_r_d;
    logic [DATA_W-1:0]   ram_wr_data_q, ram_wr_data_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            ram_addr_q    <= PARK_ADDR;
            ram_w_r_q     <= 1'b1;
            ram_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            ram_addr_q    <= ram_addr_d;
            ram_w_r_q     <= ram_w_r_d;
            ram_wr_data_q <= ram_wr_data_d;
        end
    end

    // Next state; output values are computed for the state being entered
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        rdata_d       = rdata_q;
        err_d         = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_w_r_d     = ram_w_r_q;
        ram_wr_data_d = ram_wr_data_q;

        unique case (state_q)
            IDLE: begin
                busy_d     = 1'b0;
                ram_addr_d = PARK_ADDR;
                ram_w_r_d  = 1'b1;
                if (cpu_req) begin
                    we_d   = cpu_we;
                    busy_d = 1'b1;
                    if (cpu_addr <= LAST_ADDR) begin
                        state_d       = SETUP;
                        ram_addr_d    = cpu_addr;
                        ram_wr_data_d = cpu_wdata;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                busy_d    = 1'b1;
                cnt_d     = CNT_LOAD;
                ram_w_r_d = ~we_q;
            end
            ACCESS: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    rdata_d    = we_q ? '0 : ram_rd_data;
                    ram_w_r_d  = 1'b1;
                    ram_addr_d = PARK_ADDR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                ram_w_r_d  = 1'b1;
                ram_addr_d = PARK_ADDR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu_busy    = busy_q;
    assign cpu_done    = done_q;
    assign cpu_rdata   = rdata_q;
    assign cpu_err     = err_q;
    assign ram_addr    = ram_addr_q;
    assign ram_w_r     = ram_w_r_q;
    assign ram_wr_data = ram_wr_data_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: one instance with WAIT_CYC=1, one with WAIT_CYC=3, each on a word RAM model.
module tb_ram_bus_master;

    localparam logic [31:0] PARK = 32'hFFFFFFFF;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req      [2];
    logic        we       [2];
    logic [31:0] addr     [2];
    logic [31:0] wdata    [2];
    logic        busy     [2];
    logic        done     [2];
    logic [31:0] rdata    [2];
    logic        err      [2];
    logic [31:0] ram_addr [2];
    logic        ram_w_r  [2];
    logic [31:0] ram_wd   [2];
    logic [31:0] ram_rd   [2];

    logic [31:0] mem0 [0:99];
    logic [31:0] mem1 [0:99];

    exp_t q0[$];
    exp_t q1[$];
    int   pushed0 = 0, pushed1 = 0, dcnt0 = 0, dcnt1 = 0;
    int   total = 0, bad = 0;

    ram_bus_master #(.WAIT_CYC(1)) u_w1 (
        .clk(clk), .rst(rst),
        .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]),
        .cpu_busy(busy[0]), .cpu_done(done[0]), .cpu_rdata(rdata[0]), .cpu_err(err[0]),
        .ram_addr(ram_addr[0]), .ram_w_r(ram_w_r[0]), .ram_wr_data(ram_wd[0]),
        .ram_rd_data(ram_rd[0])
    );

    ram_bus_master #(.WAIT_CYC(3)) u_w3 (
        .clk(clk), .rst(rst),
        .cpu_req(req[1]), .cpu_we(we[1]), .cpu_addr(addr[1]), .cpu_wdata(wdata[1]),
        .cpu_busy(busy[1]), .cpu_done(done[1]), .cpu_rdata(rdata[1]), .cpu_err(err[1]),
        .ram_addr(ram_addr[1]), .ram_w_r(ram_w_r[1]), .ram_wr_data(ram_wd[1]),
        .ram_rd_data(ram_rd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word RAM models: combinational read, write while ram_w_r is low
    assign ram_rd[0] = (ram_addr[0] <= 32'd99) ? mem0[ram_addr[0][6:0]] : 32'h0;
    assign ram_rd[1] = (ram_addr[1] <= 32'd99) ? mem1[ram_addr[1][6:0]] : 32'h0;

    always @(posedge clk) begin
        if (ram_w_r[0] === 1'b0 && ram_addr[0] <= 32'd99) mem0[ram_addr[0][6:0]] <= ram_wd[0];
        if (ram_w_r[1] === 1'b0 && ram_addr[1] <= 32'd99) mem1[ram_addr[1][6:0]] <= ram_wd[1];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pop on every completion pulse
    always @(negedge clk) begin
        exp_t e;
        if (done[0] === 1'b1) begin
            dcnt0++;
            chk("sb0_pending", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("sb0_err", 64'(err[0]), 64'(e.err));
                chk("sb0_rdata", 64'(rdata[0]), 64'(e.rdata));
            end
        end
        if (done[1] === 1'b1) begin
            dcnt1++;
            chk("sb1_pending", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("sb1_err", 64'(err[1]), 64'(e.err));
                chk("sb1_rdata", 64'(rdata[1]), 64'(e.rdata));
            end
        end
    end

    // One CPU transaction; pulse_n>0 re-pulses cpu_req (addr 8) in that cycle while busy
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                       input int exp_w0, input int pulse_n);
        exp_t e;
        int   n, w0, first_w0, park_bad;
        bit   seen;
        e.err   = exp_err;
        e.rdata = exp_rd;
        if (d == 0) begin q0.push_back(e); pushed0++; end
        else        begin q1.push_back(e); pushed1++; end
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        tick();
        req[d] = 1'b0;
        n = 1; w0 = 0; first_w0 = 0; park_bad = 0; seen = 1'b0;
        while (!seen && n <= 20) begin
            if (ram_w_r[d] === 1'b0) begin
                w0++;
                if (first_w0 == 0) first_w0 = n;
            end
            if (exp_err && ram_addr[d] !== PARK) park_bad++;
            if (!exp_err && n == 1) begin
                chk("setup_addr", 64'(ram_addr[d]), 64'(a));
                if (w) chk("setup_wdata", 64'(ram_wd[d]), 64'(wd));
            end
            if (done[d] === 1'b1) begin
                seen = 1'b1;
                chk("done_busy", 64'(busy[d]), 64'd1);
            end else begin
                if (n == pulse_n) begin req[d] = 1'b1; we[d] = 1'b0; addr[d] = 32'd8; end
                else req[d] = 1'b0;
                tick();
                n++;
            end
        end
        req[d] = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        chk("latency", 64'(n), 64'(exp_lat));
        chk("wr_cycles", 64'(w0), 64'(exp_w0));
        if (exp_w0 > 0) chk("wr_first", 64'(first_w0), 64'd2);
        if (exp_err) chk("parked", 64'(park_bad), 64'd0);
        tick();
        chk("idle_busy", 64'(busy[d]), 64'd0);
        chk("idle_done", 64'(done[d]), 64'd0);
        chk("idle_w_r", 64'(ram_w_r[d]), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 100; i++) begin mem0[i] = 32'h0; mem1[i] = 32'h0; end
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
        end
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", 64'(busy[d]), 64'd0);
            chk("rst_done", 64'(done[d]), 64'd0);
            chk("rst_rdata", 64'(rdata[d]), 64'd0);
            chk("rst_err", 64'(err[d]), 64'd0);
            chk("rst_addr", 64'(ram_addr[d]), 64'(PARK));
            chk("rst_w_r", 64'(ram_w_r[d]), 64'd1);
            chk("rst_wdata", 64'(ram_wd[d]), 64'd0);
        end
        tick();

        // WAIT_CYC=1: basic write/read, out-of-range and boundaries
        txn(0, 1'b1, 32'd5,       32'hDEADBEEF, 1'b0, 32'h0,        3, 1, 0);
        txn(0, 1'b0, 32'd5,       32'h0,        1'b0, 32'hDEADBEEF, 3, 0, 0);
        txn(0, 1'b0, 32'd100,     32'h0,        1'b1, 32'h0,        1, 0, 0);
        txn(0, 1'b1, 32'd0,       32'h00000001, 1'b0, 32'h0,        3, 1, 0);
        txn(0, 1'b1, 32'd99,      32'h80000000, 1'b0, 32'h0,        3, 1, 0);
        txn(0, 1'b1, 32'd100,     32'h55555555, 1'b1, 32'h0,        1, 0, 0);
        txn(0, 1'b0, 32'd0,       32'h0,        1'b0, 32'h00000001, 3, 0, 0);
        txn(0, 1'b0, 32'd99,      32'h0,        1'b0, 32'h80000000, 3, 0, 0);
        txn(0, 1'b0, 32'hFFFFFFFF, 32'h0,       1'b1, 32'h0,        1, 0, 0);
        txn(0, 1'b0, 32'd5,       32'h0,        1'b0, 32'hDEADBEEF, 3, 0, 0);

        // WAIT_CYC=3: longer access, request while busy is ignored
        txn(1, 1'b1, 32'd7, 32'h12345678, 1'b0, 32'h0,        5, 3, 0);
        txn(1, 1'b1, 32'd8, 32'hCAFEF00D, 1'b0, 32'h0,        5, 3, 0);
        txn(1, 1'b0, 32'd7, 32'h0,        1'b0, 32'h12345678, 5, 0, 2);
        tick(); tick(); tick();

        // Reset while a read is in ACCESS
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'd8;
        tick();
        req[1] = 1'b0;
        tick();
        chk("pre_rst_access_w_r", 64'(ram_w_r[1]), 64'd1);
        chk("pre_rst_addr", 64'(ram_addr[1]), 64'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy[1]), 64'd0);
        chk("mid_rst_w_r", 64'(ram_w_r[1]), 64'd1);
        chk("mid_rst_addr", 64'(ram_addr[1]), 64'(PARK));
        chk("mid_rst_rdata", 64'(rdata[1]), 64'd0);
        chk("mid_rst_done", 64'(done[1]), 64'd0);
        for (int i = 0; i < 6; i++) tick();
        txn(1, 1'b0, 32'd8, 32'h0, 1'b0, 32'hCAFEF00D, 5, 0, 0);
        txn(0, 1'b0, 32'd99, 32'h0, 1'b0, 32'h80000000, 3, 0, 0);
        tick(); tick();

        chk("done_count0", 64'(dcnt0), 64'(pushed0));
        chk("done_count1", 64'(dcnt1), 64'(pushed1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- Sequential bus master between the CPU load/store stage and the combinational word RAM on the data bus.
- Accepts one CPU request at a time and range-checks it against the RAM window.
- Sequences the RAM address, write-enable and data through SETUP/ACCESS phases, so RAM never sees a write with unsettled address or data.
- Returns read data and a one-cycle completion pulse to the CPU.

Parameters:
- DATA_W, 32, data width of CPU and RAM data paths.
- ADDR_W, 32, word-address width.
- RAM_LAST, 99, highest valid RAM word address; the window is 0..RAM_LAST.
- WAIT_CYC, 1, ACCESS-phase length in cycles; legal range 1..15.
- PARK_ADDR, 32'hFFFFFFFF, address driven while idle; it is outside the RAM window, so RAM tristates.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  request strobe, sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_busy  out  1  high whenever state != IDLE.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid while cpu_done=1.
- cpu_err  out  1  out-of-range flag; valid while cpu_done=1.
- ram_addr  out  ADDR_W  RAM address.
- ram_w_r  out  1  0 = write RAM, 1 = read RAM.
- ram_wr_data  out  DATA_W  RAM write data.
- ram_rd_data  in  DATA_W  RAM read data (combinational from RAM).

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, cpu_busy=0, cpu_done=0, cpu_rdata=0, cpu_err=0, ram_addr=PARK_ADDR, ram_w_r=1, ram_wr_data=0, wait counter=0.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - ram_w_r=1, ram_addr=PARK_ADDR.
  - On an edge with cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata (edge E0).
  - In range (cpu_addr <= RAM_LAST, unsigned): go to SETUP.
  - Out of range: go to DONE with err=1 and no RAM cycle.
- SETUP (1 cycle):
  - ram_addr = latched address, ram_wr_data = latched data, ram_w_r=1 (still read, no write).
  - Load counter with WAIT_CYC-1. Go to ACCESS.
- ACCESS (WAIT_CYC cycles):
  - Address and data held.
  - ram_w_r=0 if write, 1 if read.
  - Counter decrements each cycle; on the cycle it reads 0, go to DONE.
  - For reads, capture ram_rd_data into cpu_rdata on that final edge.
- DONE (1 cycle):
  - cpu_done=1 and cpu_busy=1.
  - cpu_err=1 only for out-of-range requests.
  - cpu_rdata = captured data for reads; 0 for writes and errors.
  - ram_w_r=1 and ram_addr=PARK_ADDR. Next state is IDLE.
- Outside DONE, cpu_done=0 and cpu_err=0. cpu_rdata holds its value until the next DONE.
- Latency, with cycle n meaning n cycles after E0:
  - In range: SETUP in cycle 1, ACCESS in cycles 2..1+WAIT_CYC, cpu_done in cycle 2+WAIT_CYC.
  - Out of range: cpu_done in cycle 1.
- Throughput: one transaction per 3+WAIT_CYC cycles. The IDLE cycle between transactions is mandatory.
- cpu_req outside IDLE (including DONE) is ignored. There is no queueing; the CPU re-asserts the request after cpu_busy falls.
- ram_w_r=0 is driven only in ACCESS of a write. It is never 0 in IDLE, SETUP or DONE, or in the cycle after rst.
- Boundaries:
  - Addresses 0 and RAM_LAST are valid.
  - Address RAM_LAST+1 and above, up to all-ones, produce an error.
- Reset mid-operation:
  - The next edge forces all reset values; no cpu_done is produced.
  - A write already in ACCESS may have reached RAM; this is acceptable.
- WAIT_CYC=0 is illegal; the implementation treats it as 1.

Test Plan:
- WAIT_CYC=1: write addr 5, data 32'hDEADBEEF -> ram_w_r=0 only in cycle 2, cpu_done in cycle 3 with cpu_err=0. Then read addr 5 -> cpu_done in cycle 3 with cpu_rdata=32'hDEADBEEF.
- Read addr 100 -> cpu_done in cycle 1, cpu_err=1, cpu_rdata=0; ram_w_r stays 1 and ram_addr stays 32'hFFFFFFFF throughout.
- Boundaries: write/read addr 0 with 32'h00000001 and addr 99 with 32'h80000000 -> both read back correctly with cpu_err=0. Addr 32'hFFFFFFFF -> cpu_err=1.
- WAIT_CYC=3: read addr 7 -> ACCESS in cycles 2-4, cpu_done in cycle 5. cpu_req pulsed in cycle 2 with addr 8 -> ignored, with no second cpu_done.
- rst asserted in ACCESS of a read -> next cycle cpu_busy=0, ram_w_r=1, ram_addr=32'hFFFFFFFF, cpu_rdata=0; no cpu_done appears. The next request then completes normally.
